// File: rtl/xyj_washer.sv
// Washing-machine program sequencer: IDLE -> WASH -> RINSE -> SPIN -> DONE,
// with per-phase elapsed counters, remaining-cycle counter, pause and abort.
module xyj_washer (
    input  logic       clk,
    input  logic       rst,
    input  logic       open,
    input  logic [0:6] i_in,
    input  logic       i_stop_1,
    output logic [0:6] i_out,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led_stop,
    output logic [0:5] i1,
    output logic [0:5] i2,
    output logic [0:5] i3,
    output logic [0:5] i4,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       a4,
    output logic       open_1,
    output logic       rst_1
);

    localparam int unsigned CW = 6;
    localparam int unsigned SW = 7;

    localparam logic [SW-1:0] SEG_0 = 7'b1111110;
    localparam logic [SW-1:0] SEG_1 = 7'b0110000;
    localparam logic [SW-1:0] SEG_2 = 7'b1101101;
    localparam logic [SW-1:0] SEG_3 = 7'b1111001;
    localparam logic [SW-1:0] SEG_4 = 7'b0110011;
    localparam logic [SW-1:0] SEG_P = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_SPIN  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d, cnt4_q, cnt4_d;
    logic          a1_q, a1_d, a2_q, a2_d, a3_q, a3_d, a4_q, a4_d;
    logic          led1_q, led1_d, led2_q, led2_d, led3_q, led3_d;
    logic          led_stop_q, led_stop_d;
    logic [SW-1:0] seg_q, seg_d;
    logic          open_1_q, open_1_d;
    logic          rst_1_q, rst_1_d;

    logic [SW-1:0] sel;
    logic [1:0]    mode_sel;
    logic [CW-1:0] cur_cnt;
    logic [CW-1:0] cur_len;

    // Phase length in cycles for a given program and phase (mode 1 is the fallback).
    function automatic logic [CW-1:0] phase_len(input logic [1:0] mode, input state_t ph);
        logic [CW-1:0] len;
        len = 6'd0;
        case (mode)
            2'd2:    len = (ph == S_WASH) ? 6'd50 : (ph == S_RINSE) ? 6'd40 : 6'd30;
            2'd3:    len = (ph == S_WASH) ? 6'd60 : (ph == S_RINSE) ? 6'd50 : 6'd40;
            default: len = (ph == S_WASH) ? 6'd20 : (ph == S_RINSE) ? 6'd15 : 6'd10;
        endcase
        return len;
    endfunction

    // Map the raw program select onto modes 1..3 (bit 0 of i_in is the MSB).
    always_comb begin
        sel = i_in;
        if (sel == 7'd0) begin
            mode_sel = 2'd1;
        end else if (sel > 7'd3) begin
            mode_sel = 2'd3;
        end else begin
            mode_sel = sel[1:0];
        end
    end

    // Elapsed counter and length of the phase currently running.
    always_comb begin
        cur_cnt = 6'd0;
        case (state_q)
            S_WASH:  cur_cnt = cnt1_q;
            S_RINSE: cur_cnt = cnt2_q;
            S_SPIN:  cur_cnt = cnt3_q;
            default: cur_cnt = 6'd0;
        endcase
        cur_len = phase_len(mode_q, state_q);
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        cnt3_d     = cnt3_q;
        cnt4_d     = cnt4_q;
        a1_d       = 1'b0;
        a2_d       = 1'b0;
        a3_d       = 1'b0;
        led_stop_d = 1'b0;

        if (!open) begin
            state_d = S_IDLE;
            mode_d  = 2'd0;
            cnt1_d  = 6'd0;
            cnt2_d  = 6'd0;
            cnt3_d  = 6'd0;
            cnt4_d  = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WASH;
                    mode_d  = mode_sel;
                    cnt1_d  = 6'd1;
                    cnt2_d  = 6'd0;
                    cnt3_d  = 6'd0;
                    cnt4_d  = phase_len(mode_sel, S_WASH) - 6'd1;
                end
                S_WASH, S_RINSE, S_SPIN: begin
                    if (i_stop_1) begin
                        led_stop_d = 1'b1;
                    end else if (cur_cnt == cur_len) begin
                        // Phase finished: hand over to the next one with its counter at 1.
                        case (state_q)
                            S_WASH: begin
                                state_d = S_RINSE;
                                cnt2_d  = 6'd1;
                                cnt4_d  = phase_len(mode_q, S_RINSE) - 6'd1;
                            end
                            S_RINSE: begin
                                state_d = S_SPIN;
                                cnt3_d  = 6'd1;
                                cnt4_d  = phase_len(mode_q, S_SPIN) - 6'd1;
                            end
                            default: begin
                                state_d = S_DONE;
                                cnt4_d  = 6'd0;
                            end
                        endcase
                    end else begin
                        // Count up; the completion pulse marks the phase's final cycle.
                        cnt4_d = cnt4_q - 6'd1;
                        case (state_q)
                            S_WASH: begin
                                cnt1_d = cnt1_q + 6'd1;
                                a1_d   = ((cnt1_q + 6'd1) == cur_len);
                            end
                            S_RINSE: begin
                                cnt2_d = cnt2_q + 6'd1;
                                a2_d   = ((cnt2_q + 6'd1) == cur_len);
                            end
                            default: begin
                                cnt3_d = cnt3_q + 6'd1;
                                a3_d   = ((cnt3_q + 6'd1) == cur_len);
                            end
                        endcase
                    end
                end
                default: begin
                    cnt4_d = 6'd0;
                end
            endcase
        end

        led1_d   = (state_d == S_WASH);
        led2_d   = (state_d == S_RINSE);
        led3_d   = (state_d == S_SPIN);
        a4_d     = (state_d == S_DONE);
        rst_1_d  = (state_d == S_IDLE);
        open_1_d = open;

        case (state_d)
            S_WASH:  seg_d = SEG_1;
            S_RINSE: seg_d = SEG_2;
            S_SPIN:  seg_d = SEG_3;
            S_DONE:  seg_d = SEG_4;
            default: seg_d = SEG_0;
        endcase
        if (led_stop_d) begin
            seg_d = SEG_P;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            cnt1_q     <= 6'd0;
            cnt2_q     <= 6'd0;
            cnt3_q     <= 6'd0;
            cnt4_q     <= 6'd0;
            a1_q       <= 1'b0;
            a2_q       <= 1'b0;
            a3_q       <= 1'b0;
            a4_q       <= 1'b0;
            led1_q     <= 1'b0;
            led2_q     <= 1'b0;
            led3_q     <= 1'b0;
            led_stop_q <= 1'b0;
            seg_q      <= SEG_0;
            open_1_q   <= 1'b0;
            rst_1_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            cnt3_q     <= cnt3_d;
            cnt4_q     <= cnt4_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            a3_q       <= a3_d;
            a4_q       <= a4_d;
            led1_q     <= led1_d;
            led2_q     <= led2_d;
            led3_q     <= led3_d;
            led_stop_q <= led_stop_d;
            seg_q      <= seg_d;
            open_1_q   <= open_1_d;
            rst_1_q    <= rst_1_d;
        end
    end

    assign i_out    = seg_q;
    assign led1     = led1_q;
    assign led2     = led2_q;
    assign led3     = led3_q;
    assign led_stop = led_stop_q;
    assign i1       = cnt1_q;
    assign i2       = cnt2_q;
    assign i3       = cnt3_q;
    assign i4       = cnt4_q;
    assign a1       = a1_q;
    assign a2       = a2_q;
    assign a3       = a3_q;
    assign a4       = a4_q;
    assign open_1   = open_1_q;
    assign rst_1    = rst_1_q;

endmodule

// File: tb/tb_xyj_washer.sv
// Directed table-driven bench for xyj_washer plus hand-written reset sequences.
module tb_xyj_washer;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] SP = 7'b1100111;

    logic       clk;
    logic       rst;
    logic       open;
    logic [0:6] i_in;
    logic       i_stop_1;
    logic [0:6] i_out;
    logic       led1, led2, led3, led_stop;
    logic [0:5] i1, i2, i3, i4;
    logic       a1, a2, a3, a4;
    logic       open_1, rst_1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       op;
        logic       stp;
        logic [6:0] sel;
        int         n;
        logic [6:0] seg;
        logic [2:0] led;
        logic       ls;
        logic [5:0] c1, c2, c3, c4;
        logic [3:0] a;
        logic       r1;
        logic       o1;
    } vec_t;

    localparam int NV = 26;
    vec_t v[NV];

    xyj_washer dut (
        .clk      (clk),
        .rst      (rst),
        .open     (open),
        .i_in     (i_in),
        .i_stop_1 (i_stop_1),
        .i_out    (i_out),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3),
        .led_stop (led_stop),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .a4       (a4),
        .open_1   (open_1),
        .rst_1    (rst_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic op, input logic stp, input logic [6:0] sel,
                                input int n, input logic [6:0] seg, input logic [2:0] led,
                                input logic ls, input logic [5:0] c1, input logic [5:0] c2,
                                input logic [5:0] c3, input logic [5:0] c4,
                                input logic [3:0] a, input logic r1, input logic o1);
        vec_t r;
        r.op = op; r.stp = stp; r.sel = sel; r.n = n; r.seg = seg; r.led = led; r.ls = ls;
        r.c1 = c1; r.c2 = c2; r.c3 = c3; r.c4 = c4; r.a = a; r.r1 = r1; r.o1 = o1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        logic [6:0] seg_act;
        seg_act = i_out;
        chk({tag, ".i_out"},    32'(seg_act), 32'(e.seg));
        chk({tag, ".led"},      32'({led1, led2, led3}), 32'(e.led));
        chk({tag, ".led_stop"}, 32'(led_stop), 32'(e.ls));
        chk({tag, ".i1"},       32'(i1), 32'(e.c1));
        chk({tag, ".i2"},       32'(i2), 32'(e.c2));
        chk({tag, ".i3"},       32'(i3), 32'(e.c3));
        chk({tag, ".i4"},       32'(i4), 32'(e.c4));
        chk({tag, ".a"},        32'({a1, a2, a3, a4}), 32'(e.a));
        chk({tag, ".rst_1"},    32'(rst_1), 32'(e.r1));
        chk({tag, ".open_1"},   32'(open_1), 32'(e.o1));
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t e;

        // Quick program with a rinse pause, DONE hold, mode mapping, abort precedence, wash pause.
        v[0]  = mk(0,0,7'd1, 2, S0,3'b000,0,  0, 0, 0, 0,4'b0000,1,0);
        v[1]  = mk(1,0,7'd1, 1, S1,3'b100,0,  1, 0, 0,19,4'b0000,0,1);
        v[2]  = mk(1,0,7'd1,18, S1,3'b100,0, 19, 0, 0, 1,4'b0000,0,1);
        v[3]  = mk(1,0,7'd1, 1, S1,3'b100,0, 20, 0, 0, 0,4'b1000,0,1);
        v[4]  = mk(1,0,7'd1, 1, S2,3'b010,0, 20, 1, 0,14,4'b0000,0,1);
        v[5]  = mk(1,1,7'd1, 3, SP,3'b010,1, 20, 1, 0,14,4'b0000,0,1);
        v[6]  = mk(1,0,7'd1, 1, S2,3'b010,0, 20, 2, 0,13,4'b0000,0,1);
        v[7]  = mk(1,0,7'd1,13, S2,3'b010,0, 20,15, 0, 0,4'b0100,0,1);
        v[8]  = mk(1,0,7'd1, 1, S3,3'b001,0, 20,15, 1, 9,4'b0000,0,1);
        v[9]  = mk(1,0,7'd1, 9, S3,3'b001,0, 20,15,10, 0,4'b0010,0,1);
        v[10] = mk(1,0,7'd1, 1, S4,3'b000,0, 20,15,10, 0,4'b0001,0,1);
        v[11] = mk(1,1,7'd1, 3, S4,3'b000,0, 20,15,10, 0,4'b0001,0,1);
        v[12] = mk(1,0,7'd3, 2, S4,3'b000,0, 20,15,10, 0,4'b0001,0,1);
        v[13] = mk(0,0,7'd3, 1, S0,3'b000,0,  0, 0, 0, 0,4'b0000,1,0);
        v[14] = mk(1,0,7'd0,20, S1,3'b100,0, 20, 0, 0, 0,4'b1000,0,1);
        v[15] = mk(1,0,7'd0, 1, S2,3'b010,0, 20, 1, 0,14,4'b0000,0,1);
        v[16] = mk(1,0,7'd7, 3, S2,3'b010,0, 20, 4, 0,11,4'b0000,0,1);
        v[17] = mk(0,0,7'd7, 1, S0,3'b000,0,  0, 0, 0, 0,4'b0000,1,0);
        v[18] = mk(1,0,7'd7, 1, S1,3'b100,0,  1, 0, 0,59,4'b0000,0,1);
        v[19] = mk(1,0,7'd7,59, S1,3'b100,0, 60, 0, 0, 0,4'b1000,0,1);
        v[20] = mk(1,0,7'd7, 1, S2,3'b010,0, 60, 1, 0,49,4'b0000,0,1);
        v[21] = mk(0,1,7'd2, 1, S0,3'b000,0,  0, 0, 0, 0,4'b0000,1,0);
        v[22] = mk(1,0,7'd1, 1, S1,3'b100,0,  1, 0, 0,19,4'b0000,0,1);
        v[23] = mk(1,1,7'd1, 5, SP,3'b100,1,  1, 0, 0,19,4'b0000,0,1);
        v[24] = mk(1,0,7'd1,19, S1,3'b100,0, 20, 0, 0, 0,4'b1000,0,1);
        v[25] = mk(1,0,7'd1, 1, S2,3'b010,0, 20, 1, 0,14,4'b0000,0,1);

        rst = 1'b0; open = 1'b1; i_in = 7'd2; i_stop_1 = 1'b0;

        // Held in reset with open high: reset values despite clock edges.
        run(2);
        e = mk(1,0,7'd2,0, S0,3'b000,0, 0,0,0,0,4'b0000,1,0);
        check_all("reset", e);

        // Standard program from reset release with open already high.
        rst = 1'b1;
        run(50);
        e = mk(1,0,7'd2,0, S1,3'b100,0, 50,0,0,0,4'b1000,0,1);
        check_all("std_e50", e);
        run(1);
        e = mk(1,0,7'd2,0, S2,3'b010,0, 50,1,0,39,4'b0000,0,1);
        check_all("std_e51", e);
        run(39);
        e = mk(1,0,7'd2,0, S2,3'b010,0, 50,40,0,0,4'b0100,0,1);
        check_all("std_e90", e);
        run(1);
        e = mk(1,0,7'd2,0, S3,3'b001,0, 50,40,1,29,4'b0000,0,1);
        check_all("std_e91", e);
        run(29);
        e = mk(1,0,7'd2,0, S3,3'b001,0, 50,40,30,0,4'b0010,0,1);
        check_all("std_e120", e);
        run(1);
        e = mk(1,0,7'd2,0, S4,3'b000,0, 50,40,30,0,4'b0001,0,1);
        check_all("std_e121", e);
        i_stop_1 = 1'b1;
        run(4);
        check_all("std_done_pause", e);
        i_stop_1 = 1'b0;

        // Abort back to IDLE before the table.
        open = 1'b0;
        run(1);

        for (int k = 0; k < NV; k++) begin
            string tag;
            open     = v[k].op;
            i_stop_1 = v[k].stp;
            i_in     = v[k].sel;
            run(v[k].n);
            tag = $sformatf("vec%0d", k);
            check_all(tag, v[k]);
        end

        // Asynchronous reset mid-SPIN, then restart from reset release.
        open = 1'b0; i_stop_1 = 1'b0; i_in = 7'd2;
        run(1);
        open = 1'b1;
        run(95);
        e = mk(1,0,7'd2,0, S3,3'b001,0, 50,40,5,25,4'b0000,0,1);
        check_all("spin_pre_rst", e);
        #2;
        rst = 1'b0;
        #1;
        e = mk(1,0,7'd2,0, S0,3'b000,0, 0,0,0,0,4'b0000,1,0);
        check_all("async_rst", e);
        @(negedge clk);
        rst = 1'b1;
        run(1);
        e = mk(1,0,7'd2,0, S1,3'b100,0, 1,0,0,49,4'b0000,0,1);
        check_all("restart", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
